// File: rtl/ultrasonic_ranger_multi.sv
// Round-robin scanner for NUM_CH HC-SR04-style ultrasonic sensors.
// Each channel is triggered and timed, and its echo width is converted to cm.
// Results carry a timeout flag, and each channel has its own near/obstacle bit.
module ultrasonic_ranger_multi #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned CM_CYCLES      = 5800,
  parameter int unsigned TIMEOUT_CYCLES = 3000000,
  parameter int unsigned GAP_CYCLES     = 6000000,
  parameter int unsigned DIST_W         = 9,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] echo,
  input  logic [DIST_W-1:0] near_thresh,
  output logic [NUM_CH-1:0] trig,
  output logic              dist_valid,
  output logic [CH_W-1:0]   dist_ch,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_timeout,
  output logic [NUM_CH-1:0] near
);

  localparam int unsigned SUB_W   = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
  localparam int unsigned CNT_T   = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (CNT_T > GAP_CYCLES) ? CNT_T : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  // Largest reportable distance; all-ones is kept free for the timeout code
  localparam logic [DIST_W-1:0] CM_SAT = {{(DIST_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t             state;
  logic [CH_W-1:0]    ptr;
  logic [NUM_CH-1:0]  echo_m;
  logic [NUM_CH-1:0]  echo_s;
  logic               echo_prev;
  logic [CNT_W-1:0]   tcnt;
  logic [SUB_W-1:0]   sub;
  logic [DIST_W-1:0]  cm;

  logic echo_act;
  logic rise;
  logic to_hit;
  logic fall_done;
  logic done;
  logic timed_out;

  // Edge detection on the active channel and end-of-measurement decode
  always_comb begin
    echo_act  = echo_s[ptr];
    rise      = echo_act & ~echo_prev;
    to_hit    = ((state == WAIT_RISE) || (state == MEASURE)) &&
                (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
    fall_done = (state == MEASURE) && !echo_act;
    done      = fall_done || to_hit;
    timed_out = to_hit && !fall_done;
  end

  // Synchroniser, scan FSM, echo timer and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      echo_m       <= '0;
      echo_s       <= '0;
      echo_prev    <= 1'b0;
      tcnt         <= '0;
      sub          <= '0;
      cm           <= '0;
      trig         <= '0;
      dist_valid   <= 1'b0;
      dist_ch      <= '0;
      dist_cm      <= '0;
      dist_timeout <= 1'b0;
      near         <= '0;
    end else begin
      echo_m     <= echo;
      echo_s     <= echo_m;
      echo_prev  <= echo_act;
      dist_valid <= 1'b0;
      if (done) begin
        // A falling echo wins over a timeout that lands on the same cycle
        dist_valid   <= 1'b1;
        dist_ch      <= ptr;
        dist_cm      <= timed_out ? '1 : cm;
        dist_timeout <= timed_out;
        near[ptr]    <= !timed_out && (cm <= near_thresh);
        tcnt         <= '0;
        state        <= GAP;
      end else begin
        case (state)
          IDLE: begin
            if (enable) begin
              trig[ptr] <= 1'b1;
              tcnt      <= '0;
              state     <= TRIG;
            end
          end
          TRIG: begin
            if (tcnt == CNT_W'(TRIG_CYCLES - 1)) begin
              trig  <= '0;
              tcnt  <= '0;
              state <= WAIT_RISE;
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
          WAIT_RISE: begin
            tcnt <= tcnt + CNT_W'(1);
            if (rise) begin
              // The rising cycle is the first high cycle and is counted here
              if (CM_CYCLES == 1) begin
                sub <= '0;
                cm  <= DIST_W'(1);
              end else begin
                sub <= SUB_W'(1);
                cm  <= '0;
              end
              state <= MEASURE;
            end
          end
          MEASURE: begin
            tcnt <= tcnt + CNT_W'(1);
            if (sub == SUB_W'(CM_CYCLES - 1)) begin
              sub <= '0;
              if (cm != CM_SAT) cm <= cm + DIST_W'(1);
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
          GAP: begin
            if (tcnt == CNT_W'(GAP_CYCLES - 1)) begin
              tcnt  <= '0;
              ptr   <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + CH_W'(1);
              state <= IDLE;
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// Directed bench for ultrasonic_ranger_multi with small timing parameters.
module tb_ultrasonic_ranger_multi;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DIST_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NUM_CH-1:0] echo;
  logic [DIST_W-1:0] near_thresh;
  logic [NUM_CH-1:0] trig;
  logic              dist_valid;
  logic [1:0]        dist_ch;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_timeout;
  logic [NUM_CH-1:0] near;

  int checks = 0;
  int errors = 0;

  ultrasonic_ranger_multi #(
    .NUM_CH(NUM_CH), .TRIG_CYCLES(5), .CM_CYCLES(10),
    .TIMEOUT_CYCLES(2000), .GAP_CYCLES(50), .DIST_W(DIST_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .near_thresh(near_thresh),
    .trig(trig), .dist_valid(dist_valid), .dist_ch(dist_ch), .dist_cm(dist_cm),
    .dist_timeout(dist_timeout), .near(near)
  );

  always #5 clk = ~clk;

  // Bounded wait for any trigger bit to go high
  task automatic wait_trig(input int budget, output logic [NUM_CH-1:0] seen, output bit ok);
    int i;
    ok = 1'b0; seen = '0; i = 0;
    while (!ok && i < budget) begin
      @(negedge clk);
      i++;
      if (trig != '0) begin seen = trig; ok = 1'b1; end
    end
  endtask

  // Bounded wait for the trigger pulse to end
  task automatic wait_trig_low(input int budget, output bit ok);
    int i;
    ok = (trig == '0); i = 0;
    while (!ok && i < budget) begin
      @(negedge clk);
      i++;
      if (trig == '0) ok = 1'b1;
    end
  endtask

  // Bounded wait for a result pulse; n is the number of cycles waited
  task automatic wait_valid(input int budget, output int n, output bit ok);
    ok = 1'b0; n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (dist_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (trig !== 3'b000) begin errors++; $display("FAIL reset_trig: got %b expected 000", trig); end
    checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dist_valid); end
    checks++; if (dist_cm !== 9'd0) begin errors++; $display("FAIL reset_cm: got %0d expected 0", dist_cm); end
    checks++; if (dist_ch !== 2'd0 || dist_timeout !== 1'b0) begin errors++; $display("FAIL reset_ch_to: got ch=%0d to=%b expected 0/0", dist_ch, dist_timeout); end
    checks++; if (near !== 3'b000) begin errors++; $display("FAIL reset_near: got %b expected 000", near); end
  endtask

  task automatic test_trig_width();
    logic [NUM_CH-1:0] seen; bit ok; int w; logic [1:0] other;
    rst = 1'b0; enable = 1'b1;
    wait_trig(20, seen, ok);
    checks++; if (!ok || seen !== 3'b001) begin errors++; $display("FAIL first_trig: got %b ok=%0d expected 001", seen, ok); end
    w = 0; other = '0;
    while (trig[0] === 1'b1 && w < 50) begin
      w++; other |= trig[2:1];
      @(negedge clk);
    end
    checks++; if (w != 5) begin errors++; $display("FAIL trig_width: got %0d expected 5", w); end
    checks++; if (other !== 2'b00) begin errors++; $display("FAIL trig_others: got %b expected 00", other); end
  endtask

  task automatic test_measure_ch0();
    int n; bit ok;
    echo[0] = 1'b1;
    repeat (250) @(negedge clk);
    echo[0] = 1'b0;
    wait_valid(100, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ch0_valid: got none expected pulse"); end
    checks++; if (dist_ch !== 2'd0 || dist_cm !== 9'd25 || dist_timeout !== 1'b0) begin errors++; $display("FAIL ch0_result: got ch=%0d cm=%0d to=%b expected 0/25/0", dist_ch, dist_cm, dist_timeout); end
    checks++; if (near !== 3'b001) begin errors++; $display("FAIL ch0_near30: got %b expected 001", near); end
    @(negedge clk);
    checks++; if (dist_valid !== 1'b0 || dist_cm !== 9'd25) begin errors++; $display("FAIL ch0_pulse_hold: got v=%b cm=%0d expected 0/25", dist_valid, dist_cm); end
  endtask

  task automatic test_timeout_ch1();
    logic [NUM_CH-1:0] seen; bit ok; int n;
    echo[2] = 1'b1;
    wait_trig(100, seen, ok);
    checks++; if (!ok || seen !== 3'b010) begin errors++; $display("FAIL ch1_trig: got %b expected 010", seen); end
    wait_trig_low(20, ok);
    wait_valid(2100, n, ok);
    checks++; if (!ok || n != 2000) begin errors++; $display("FAIL ch1_timeout_latency: got %0d expected 2000", n); end
    checks++; if (dist_ch !== 2'd1 || dist_cm !== 9'd511 || dist_timeout !== 1'b1) begin errors++; $display("FAIL ch1_result: got ch=%0d cm=%0d to=%b expected 1/511/1", dist_ch, dist_cm, dist_timeout); end
    checks++; if (near !== 3'b001) begin errors++; $display("FAIL ch1_near: got %b expected 001", near); end
  endtask

  task automatic test_echo_held_ch2();
    logic [NUM_CH-1:0] seen; bit ok; int n;
    wait_trig(100, seen, ok);
    checks++; if (!ok || seen !== 3'b100) begin errors++; $display("FAIL ch2_trig: got %b expected 100", seen); end
    wait_trig_low(20, ok);
    wait_valid(2100, n, ok);
    checks++; if (!ok || dist_ch !== 2'd2 || dist_cm !== 9'd511 || dist_timeout !== 1'b1) begin errors++; $display("FAIL ch2_held: got ok=%0d ch=%0d cm=%0d to=%b expected 1/2/511/1", ok, dist_ch, dist_cm, dist_timeout); end
    echo[2] = 1'b0;
  endtask

  task automatic test_round_robin_gap();
    int n;
    n = 0;
    while (trig == '0 && n < 200) begin
      @(negedge clk);
      if (trig == '0) n++;
    end
    checks++; if (n != 50) begin errors++; $display("FAIL gap_cycles: got %0d expected 50", n); end
    checks++; if (trig !== 3'b001) begin errors++; $display("FAIL wrap_trig: got %b expected 001", trig); end
  endtask

  task automatic test_thresh_low();
    bit ok; int n;
    near_thresh = 9'd20;
    wait_trig_low(20, ok);
    echo[0] = 1'b1;
    repeat (250) @(negedge clk);
    echo[0] = 1'b0;
    wait_valid(100, n, ok);
    checks++; if (!ok || dist_cm !== 9'd25 || near !== 3'b000) begin errors++; $display("FAIL ch0_near20: got cm=%0d near=%b expected 25/000", dist_cm, near); end
  endtask

  task automatic test_near_limit();
    logic [NUM_CH-1:0] seen; bit ok; int n; int got; logic [DIST_W-1:0] cm_s; logic to_s;
    wait_trig(100, seen, ok);
    wait_trig_low(20, ok);
    echo[1] = 1'b1;
    got = 0; cm_s = '0; to_s = 1'b0;
    for (int i = 0; i < 1999; i++) begin
      @(negedge clk);
      if (dist_valid === 1'b1) begin got++; cm_s = dist_cm; to_s = dist_timeout; end
    end
    echo[1] = 1'b0;
    if (got == 0) begin
      wait_valid(100, n, ok);
      if (ok) begin got = 1; cm_s = dist_cm; to_s = dist_timeout; end
    end
    checks++; if (got != 1 || dist_ch !== 2'd1) begin errors++; $display("FAIL limit_pulse: got %0d pulses ch=%0d expected 1 on ch1", got, dist_ch); end
    checks++; if (!((to_s === 1'b1 && cm_s === 9'd511) || (to_s === 1'b0 && cm_s === 9'd199))) begin errors++; $display("FAIL limit_result: got cm=%0d to=%b expected 511/1 or 199/0", cm_s, to_s); end
  endtask

  task automatic test_reset_mid();
    logic [NUM_CH-1:0] seen; bit ok; int n;
    wait_trig(100, seen, ok);
    wait_trig_low(20, ok);
    wait_valid(2100, n, ok);
    wait_trig(100, seen, ok);
    wait_trig_low(20, ok);
    echo[0] = 1'b1;
    repeat (30) @(negedge clk);
    echo[0] = 1'b0;
    wait_valid(100, n, ok);
    checks++; if (!ok || dist_cm !== 9'd3 || near !== 3'b001) begin errors++; $display("FAIL short_ch0: got cm=%0d near=%b expected 3/001", dist_cm, near); end
    wait_trig(100, seen, ok);
    checks++; if (!ok || seen !== 3'b010) begin errors++; $display("FAIL pre_rst_trig: got %b expected 010", seen); end
    wait_trig_low(20, ok);
    echo[1] = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (trig !== 3'b000 || dist_valid !== 1'b0 || dist_cm !== 9'd0) begin errors++; $display("FAIL rst_mid: got trig=%b v=%b cm=%0d expected 000/0/0", trig, dist_valid, dist_cm); end
    checks++; if (near !== 3'b000 || dist_ch !== 2'd0 || dist_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got near=%b ch=%0d to=%b expected 000/0/0", near, dist_ch, dist_timeout); end
    repeat (3) @(negedge clk);
    echo = '0;
    rst = 1'b0;
    wait_trig(20, seen, ok);
    checks++; if (!ok || seen !== 3'b001) begin errors++; $display("FAIL rst_restart: got %b expected 001", seen); end
  endtask

  task automatic test_enable_drop();
    logic [NUM_CH-1:0] seen; bit ok; int n; bit any;
    wait_trig_low(20, ok);
    echo[0] = 1'b1;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    echo[2:1] = 2'b11;
    repeat (60) @(negedge clk);
    echo = '0;
    wait_valid(100, n, ok);
    checks++; if (!ok || dist_ch !== 2'd0 || dist_cm !== 9'd12 || dist_timeout !== 1'b0) begin errors++; $display("FAIL en_drop_result: got ok=%0d ch=%0d cm=%0d to=%b expected 1/0/12/0", ok, dist_ch, dist_cm, dist_timeout); end
    any = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (trig != '0) any = 1'b1;
    end
    checks++; if (any) begin errors++; $display("FAIL en_drop_parked: got trig activity expected none"); end
    enable = 1'b1;
    wait_trig(20, seen, ok);
    checks++; if (!ok || seen !== 3'b010) begin errors++; $display("FAIL en_resume: got %b expected 010", seen); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; echo = '0; near_thresh = 9'd30;
    test_reset();
    test_trig_width();
    test_measure_ch0();
    test_timeout_ch1();
    test_echo_held_ch2();
    test_round_robin_gap();
    test_thresh_low();
    test_near_limit();
    test_reset_mid();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
